// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with a registered ripple
// carry, then publishes the result and carry/overflow/zero/negative flags on done.
module chunked_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int K     = WIDTH / CHUNK;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int IW    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_idx;

  logic [WIDTH-1:0] r_sum;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  logic [IW-1:0]    w_base;
  logic [CHUNK-1:0] w_ac;
  logic [CHUNK-1:0] w_bc;
  logic [CHUNK:0]   w_csum;
  logic [WIDTH-1:0] w_res_nx;
  logic             w_c_msb;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = RUN;
          w_accept   = 1'b1;
        end
      end
      RUN: begin
        if (r_idx == LAST) begin
          w_state_nx = IDLE;
          w_last     = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // One chunk of the ripple add; the MSB carry-in is recovered from the sum bit.
  always_comb begin
    w_base   = IW'(r_idx) * IW'(CHUNK);
    w_ac     = r_a[w_base +: CHUNK];
    w_bc     = r_b[w_base +: CHUNK];
    w_csum   = {1'b0, w_ac} + {1'b0, w_bc} + (CHUNK+1)'(r_carry);
    w_res_nx = r_res;
    w_res_nx[w_base +: CHUNK] = w_csum[CHUNK-1:0];
    w_c_msb  = w_ac[CHUNK-1] ^ w_bc[CHUNK-1] ^ w_csum[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub ? 1'b1 : cin;
        r_idx   <= '0;
      end else if (r_state == RUN) begin
        r_res   <= w_res_nx;
        r_carry <= w_csum[CHUNK];
        if (w_last) begin
          r_idx  <= '0;
          r_sum  <= w_res_nx;
          r_cout <= w_csum[CHUNK];
          r_ovf  <= w_c_msb ^ w_csum[CHUNK];
          r_zero <= (w_res_nx == '0);
          r_neg  <= w_res_nx[WIDTH-1];
        end else begin
          r_idx  <= r_idx + CNT_W'(1);
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
  assign neg  = r_neg;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: a 32/8 instance and an 8/1 instance, compared against
// an arithmetic reference model (integer add/subtract with signed range check).
module tb_chunked_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;

  logic        w_start, w_sub, w_cin;
  logic [31:0] w_a, w_b;
  logic        w_busy, w_done, w_cout, w_ovf, w_zero, w_neg;
  logic [31:0] w_sum;

  logic        e_start, e_sub, e_cin;
  logic [7:0]  e_a, e_b;
  logic        e_busy, e_done, e_cout, e_ovf, e_zero, e_neg;
  logic [7:0]  e_sum;

  chunked_add_sub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(w_start), .sub(w_sub), .cin(w_cin),
    .a(w_a), .b(w_b), .busy(w_busy), .done(w_done), .sum(w_sum),
    .cout(w_cout), .ovf(w_ovf), .zero(w_zero), .neg(w_neg));

  chunked_add_sub #(.WIDTH(8), .CHUNK(1)) dut8 (
    .clk(clk), .rst(rst), .start(e_start), .sub(e_sub), .cin(e_cin),
    .a(e_a), .b(e_b), .busy(e_busy), .done(e_done), .sum(e_sum),
    .cout(e_cout), .ovf(e_ovf), .zero(e_zero), .neg(e_neg));

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input bit sv, input bit cv);
    longint unsigned mask, ua, ub, badj, tot, halfu;
    longint          sa, sb, ideal, half;
    res_t            r;
    mask  = (64'd1 << w) - 64'd1;
    ua    = 64'(av) & mask;
    ub    = 64'(bv) & mask;
    halfu = 64'd1 << (w - 1);
    half  = longint'(halfu);
    badj  = sv ? (~ub & mask) : ub;
    tot   = ua + badj + (sv ? 64'd1 : 64'(cv));
    sa    = (ua >= halfu) ? longint'(ua) - 2 * half : longint'(ua);
    sb    = (ub >= halfu) ? longint'(ub) - 2 * half : longint'(ub);
    ideal = sv ? sa - sb : sa + sb + longint'(cv);
    r.sum  = 32'(tot & mask);
    r.cout = ((tot >> w) & 64'd1) != 0;
    r.ovf  = (ideal >= half) || (ideal < -half);
    r.zero = (r.sum == 32'd0);
    r.neg  = ((tot >> (w - 1)) & 64'd1) != 0;
    return r;
  endfunction

  function automatic res_t obs(input bit s8);
    if (s8) return {24'd0, e_sum, e_cout, e_ovf, e_zero, e_neg};
    return {w_sum, w_cout, w_ovf, w_zero, w_neg};
  endfunction

  function automatic logic get_busy(input bit s8);
    return s8 ? e_busy : w_busy;
  endfunction

  function automatic logic get_done(input bit s8);
    return s8 ? e_done : w_done;
  endfunction

  task automatic drive(input bit s8, input logic st, input logic [31:0] av,
                       input logic [31:0] bv, input logic sv, input logic cv);
    if (s8) begin
      e_start = st; e_a = av[7:0]; e_b = bv[7:0]; e_sub = sv; e_cin = cv;
    end else begin
      w_start = st; w_a = av; w_b = bv; w_sub = sv; w_cin = cv;
    end
  endtask

  // Issues one start (now=1: in the current cycle) and follows it to done.
  // lat = negedges after the start edge until done (-1 on timeout); inj>0 pulses
  // a stray start at that negedge; held = outputs unchanged while running.
  task automatic do_op(input bit s8, input bit now, input logic [31:0] av,
                       input logic [31:0] bv, input bit sv, input bit cv, input int inj,
                       output int lat, output int bcnt, output bit held);
    res_t prev;
    if (!now) @(negedge clk);
    prev = obs(s8);
    drive(s8, 1'b1, av, bv, sv, cv);
    lat  = -1;
    bcnt = 0;
    held = 1'b1;
    for (int n = 0; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      drive(s8, (inj > 0 && n == inj), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (get_busy(s8)) bcnt++;
      if (get_done(s8)) lat = n;
      else if (obs(s8) !== prev) held = 1'b0;
    end
    drive(s8, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 32'h55, 32'h0F, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (w_busy !== 1'b0) $display("FAIL reset_busy32: got %b expected 0", w_busy); else n_pass++;
    n_checks++; if (w_done !== 1'b0) $display("FAIL reset_done32: got %b expected 0", w_done); else n_pass++;
    n_checks++; if (obs(1'b0) !== res_t'(0)) $display("FAIL reset_outs32: got %h expected 0", obs(1'b0)); else n_pass++;
    n_checks++; if (obs(1'b1) !== res_t'(0) || e_busy !== 1'b0) $display("FAIL reset_outs8: got %h/%b expected 0/0", obs(1'b1), e_busy); else n_pass++;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (w_busy !== 1'b0 || w_done !== 1'b0) $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", w_busy, w_done); else n_pass++;
  endtask

  task automatic test_add;
    int lat, bcnt; bit held; res_t exp;
    do_op(1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, lat, bcnt, held);
    exp = {32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
    n_checks++; if (obs(1'b0) !== exp) $display("FAIL add_basic: got %h expected %h", obs(1'b0), exp); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL add_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (bcnt !== 4) $display("FAIL add_busy_cycles: got %0d expected 4", bcnt); else n_pass++;
    n_checks++; if (held !== 1'b1) $display("FAIL add_hold: got %b expected 1", held); else n_pass++;
    @(negedge clk);
    n_checks++; if (w_done !== 1'b0) $display("FAIL add_done_pulse: got %b expected 0", w_done); else n_pass++;
  endtask

  task automatic test_random32;
    int lat, bcnt; bit held, now, sv, cv; logic [31:0] av, bv; res_t exp;
    for (int i = 0; i < 20; i++) begin
      av  = $urandom; bv = $urandom;
      if (i % 5 == 0) bv = av;
      sv  = 1'($urandom_range(0, 1)); cv = 1'($urandom_range(0, 1));
      now = (i > 0) && ($urandom_range(0, 1) == 1);
      exp = model(32, av, bv, sv, cv);
      do_op(1'b0, now, av, bv, sv, cv, 0, lat, bcnt, held);
      n_checks++; if (obs(1'b0) !== exp || lat !== 4 || held !== 1'b1)
        $display("FAIL rand32_%0d: got %h lat=%0d held=%b expected %h lat=4 held=1", i, obs(1'b0), lat, held, exp);
      else n_pass++;
    end
  endtask

  task automatic test_overflow;
    int lat, bcnt; bit held; res_t exp;
    do_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, lat, bcnt, held);
    exp = {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs(1'b0) !== exp) $display("FAIL ovf_pos: got %h expected %h", obs(1'b0), exp); else n_pass++;
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, lat, bcnt, held);
    exp = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    n_checks++; if (obs(1'b0) !== exp) $display("FAIL wrap_zero: got %h expected %h", obs(1'b0), exp); else n_pass++;
  endtask

  task automatic test_subtract;
    int lat, bcnt; bit held; res_t exp;
    do_op(1'b0, 1'b0, 32'd5, 32'd5, 1'b1, 1'b0, 0, lat, bcnt, held);
    exp = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    n_checks++; if (obs(1'b0) !== exp) $display("FAIL sub_equal: got %h expected %h", obs(1'b0), exp); else n_pass++;
    do_op(1'b0, 1'b0, 32'd0, 32'd1, 1'b1, 1'b1, 0, lat, bcnt, held);
    exp = {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    n_checks++; if (obs(1'b0) !== exp) $display("FAIL sub_borrow: got %h expected %h", obs(1'b0), exp); else n_pass++;
  endtask

  task automatic test_ignore_start;
    int lat, bcnt; bit held; logic [31:0] av, bv; res_t exp;
    av = $urandom; bv = $urandom;
    exp = model(32, av, bv, 1'b0, 1'b1);
    do_op(1'b0, 1'b0, av, bv, 1'b0, 1'b1, 2, lat, bcnt, held);
    n_checks++; if (obs(1'b0) !== exp) $display("FAIL ignore_start_result: got %h expected %h", obs(1'b0), exp); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL ignore_start_latency: got %0d expected 4", lat); else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++; if (w_busy !== 1'b0 || w_done !== 1'b0) $display("FAIL ignore_start_no_queue: got busy=%b done=%b expected 0/0", w_busy, w_done); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int dones;
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (w_busy !== 1'b0 || w_done !== 1'b0) $display("FAIL rst_mid_state: got busy=%b done=%b expected 0/0", w_busy, w_done); else n_pass++;
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (w_done === 1'b1 || w_busy === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", dones); else n_pass++;
    n_checks++; if (obs(1'b0) !== res_t'(0)) $display("FAIL rst_mid_outs: got %h expected 0", obs(1'b0)); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, bcnt; bit held; res_t exp;
    do_op(1'b1, 1'b0, 32'hFF, 32'h01, 1'b0, 1'b1, 0, lat, bcnt, held);
    exp = {32'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    n_checks++; if (obs(1'b1) !== exp) $display("FAIL w8_add_cin: got %h expected %h", obs(1'b1), exp); else n_pass++;
    n_checks++; if (lat !== 8) $display("FAIL w8_latency: got %0d expected 8", lat); else n_pass++;
    do_op(1'b1, 1'b1, 32'h80, 32'h80, 1'b0, 1'b0, 0, lat, bcnt, held);
    exp = {32'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    n_checks++; if (obs(1'b1) !== exp) $display("FAIL b2b_result: got %h expected %h", obs(1'b1), exp); else n_pass++;
    n_checks++; if (lat !== 8 || bcnt !== 8 || held !== 1'b1) $display("FAIL b2b_timing: got lat=%0d busy=%0d held=%b expected 8/8/1", lat, bcnt, held); else n_pass++;
  endtask

  task automatic test_random8;
    int lat, bcnt; bit held, sv, cv; logic [31:0] av, bv; res_t exp;
    for (int i = 0; i < 10; i++) begin
      av = 32'($urandom_range(0, 255)); bv = 32'($urandom_range(0, 255));
      sv = 1'($urandom_range(0, 1)); cv = 1'($urandom_range(0, 1));
      exp = model(8, av, bv, sv, cv);
      do_op(1'b1, (i > 0), av, bv, sv, cv, 0, lat, bcnt, held);
      n_checks++; if (obs(1'b1) !== exp || lat !== 8)
        $display("FAIL rand8_%0d: got %h lat=%0d expected %h lat=8", i, obs(1'b1), lat, exp);
      else n_pass++;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    test_reset;
    test_add;
    test_overflow;
    test_subtract;
    test_random32;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random8;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chunked_add_sub.md
Name: chunked_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor for the CPU datapath; successor to the single-bit full-adder cell.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry through a registered carry between cycles.
- Provides a start/busy/done handshake and ALU status flags: carry, overflow, zero, negative.
- Sits beside the ALU; the control unit starts it and waits on done.

Parameters:
WIDTH, 32, operand/result width in bits; must be ≥ 2
CHUNK, 8, bits added per clock; WIDTH must be an integer multiple of CHUNK (K = WIDTH/CHUNK cycles)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 (cin ignored)
cin  input  1  carry-in for add mode
a  input  WIDTH  operand A, captured at accepted start
b  input  WIDTH  operand B, captured at accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  result, held until next completion
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  signed overflow
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]

Behaviour:
- Reset: rst sampled high at a clock edge forces state IDLE.
  - Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, neg=0.
  - Internal operand, carry and chunk-counter registers are cleared.
  - rst has priority over every other input, including mid-operation; the aborted operation never produces done.
- States: IDLE and RUN.
- IDLE → RUN: at an edge with start=1 and busy=0 (done=1 in the same cycle is allowed).
  - Latch A=a.
  - Latch B = sub ? ~b : b.
  - Latch carry = sub ? 1 : cin.
  - Chunk index i=0; busy=1 from that edge.
- RUN: at each edge, add chunk i: {c, r[i]} = A[i] + B[i] + carry, where chunk i covers bits [i*CHUNK +: CHUNK].
  - Store r[i] into an internal result register; carry ← c; i ← i+1.
  - For the top chunk, also record the carry into bit WIDTH-1.
- Completion: at the edge processing chunk K-1:
  - State → IDLE, busy=0, done=1 for exactly one cycle.
  - sum ← full internal result.
  - cout ← final carry.
  - ovf ← (carry into MSB) XOR (carry out of MSB).
  - zero ← (result == 0); neg ← result MSB.
- Latency: start sampled at edge E0; chunks are computed at E1..EK; done is high in the cycle after edge EK. For defaults, done appears after the 4th edge following E0.
- Output stability: sum and the flags change only at a completion edge or rst. They hold the previous result throughout RUN.
- start while busy=1 is ignored; no queuing.
- a, b, cin, sub are don't-care except at the accepted start edge.
- Back-to-back: start=1 in the done cycle is accepted. Busy then rises on that edge, and done falls the same edge.
- Wrap-around: the result is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
- CHUNK=WIDTH is legal: K=1, done one cycle after the start edge.

Test Plan:
1. Reset: assert rst for 2 cycles with start=1 → busy=0, done=0, sum=0x00000000, all flags 0; no operation starts.
2. Add: a=0x000000FF, b=0x00000001, cin=0, sub=0, start one cycle → busy=1 for 4 cycles; done pulse once; sum=0x00000100, cout=0, ovf=0, zero=0, neg=0.
3. Signed overflow: a=0x7FFFFFFF, b=0x00000001 add → sum=0x80000000, ovf=1, neg=1, cout=0. Then a=0xFFFFFFFF, b=0x00000001 add → sum=0, cout=1, zero=1, ovf=0.
4. Subtract: a=5, b=5, sub=1 → sum=0, zero=1, cout=1. Then a=0, b=1, sub=1 (cin=1, ignored) → sum=0xFFFFFFFF, cout=0, neg=1, ovf=0.
5. Handshake and reset:
   - Pulse start again two cycles into RUN with different operands → ignored; the first result completes on time.
   - Assert rst on the 2nd RUN cycle → busy=0 next cycle, no done; sum keeps its reset value 0.
6. Parameterisation: WIDTH=8, CHUNK=1, a=0xFF, b=0x01, cin=1 → done after 8 edges, sum=0x01, cout=1, ovf=0. Also test back-to-back start in the done cycle: a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1, zero=1.
